// File: rtl/n64_pkg.sv
// Shared constants, FSM state encoding and payload layout for the N64 controller frame receiver.
`timescale 1ns/1ps
package n64_pkg;

    localparam int unsigned HDR_BITS     = 9;
    localparam int unsigned FRAME_BITS   = 41;
    localparam int unsigned PAYLOAD_BITS = 32;
    localparam int unsigned CNT_W        = 16;
    localparam int unsigned IDX_W        = 6;
    localparam int unsigned ERR_CNT_W    = 8;

    localparam logic [HDR_BITS-1:0] HDR_VALUE = 9'b0_0000_0011;

    localparam int unsigned BTN_A     = 15;
    localparam int unsigned BTN_B     = 14;
    localparam int unsigned BTN_Z     = 13;
    localparam int unsigned BTN_START = 12;
    localparam int unsigned BTN_GU    = 11;
    localparam int unsigned BTN_GD    = 10;
    localparam int unsigned BTN_GL    = 9;
    localparam int unsigned BTN_GR    = 8;
    localparam int unsigned BTN_RSV1  = 7;
    localparam int unsigned BTN_RSV0  = 6;
    localparam int unsigned BTN_L     = 5;
    localparam int unsigned BTN_R     = 4;
    localparam int unsigned BTN_YU    = 3;
    localparam int unsigned BTN_YD    = 2;
    localparam int unsigned BTN_YL    = 1;
    localparam int unsigned BTN_YR    = 0;

    typedef enum logic [2:0] {
        ST_RECOVER,
        ST_IDLE,
        ST_START,
        ST_HIGH,
        ST_LOW,
        ST_CHECK,
        ST_TAIL
    } state_e;

    // Payload in arrival order: first received bit lands in buttons[15].
    typedef struct packed {
        logic [15:0] buttons;
        logic [7:0]  joy_x;
        logic [7:0]  joy_y;
    } pad_frame_t;

    function automatic logic hdr_ok(input logic [FRAME_BITS-1:0] sr);
        return sr[FRAME_BITS-1 -: HDR_BITS] == HDR_VALUE;
    endfunction

endpackage

// File: rtl/n64_line_sync.sv
// Two-flop synchroniser for the controller pin plus registered rise/fall pulses.
`timescale 1ns/1ps
module n64_line_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic line_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;
    logic rise_q;
    logic fall_q;

    // Idle-high reset so a released reset never fakes a falling edge on a quiet line.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= line_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            rise_q  <= sync2_q & ~prev_q;
            fall_q  <= ~sync2_q & prev_q;
        end
    end

    assign level_o = prev_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/n64_frame_receiver.sv
// N64 single-wire frame decoder: pulse-width bit slicer, header check and registered payload outputs.
`timescale 1ns/1ps
module n64_frame_receiver
    import n64_pkg::*;
#(
    parameter int unsigned CLK_PERIOD_NS = 20,
    parameter int unsigned THRESH_NS     = 1650,
    parameter int unsigned MIN_HIGH_NS   = 200,
    parameter int unsigned TIMEOUT_NS    = 8000
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 n64_in,
    output logic [15:0]          buttons,
    output logic [7:0]           joy_x,
    output logic [7:0]           joy_y,
    output logic                 frame_valid,
    output logic                 frame_err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam int unsigned THR_C = THRESH_NS / CLK_PERIOD_NS;
    localparam int unsigned MIN_C = MIN_HIGH_NS / CLK_PERIOD_NS;
    localparam int unsigned TO_C  = TIMEOUT_NS / CLK_PERIOD_NS;

    logic level;
    logic rise;
    logic fall;

    state_e                 state_q,   state_d;
    logic [CNT_W-1:0]       cnt_q,     cnt_d;
    logic [IDX_W-1:0]       idx_q,     idx_d;
    logic [FRAME_BITS-1:0]  sr_q,      sr_d;
    pad_frame_t             frame_q,   frame_d;
    logic                   valid_q,   valid_d;
    logic                   err_q,     err_d;
    logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;
    logic                   timeout;

    n64_line_sync u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .line_i  (n64_in),
        .level_o (level),
        .rise_o  (rise),
        .fall_o  (fall)
    );

    // Phase timer: restarts on every edge; in RECOVER it only counts unbroken high time.
    always_comb begin
        cnt_d = cnt_q;
        if (rise || fall || (state_q == ST_RECOVER && !level)) begin
            cnt_d = '0;
        end else if (cnt_q < CNT_W'(TO_C)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign timeout = (cnt_q >= CNT_W'(TO_C));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        sr_d    = sr_q;
        frame_d = frame_q;
        valid_d = 1'b0;
        err_d   = 1'b0;

        unique case (state_q)
            ST_RECOVER: begin
                if (level && timeout) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (fall) begin
                    state_d = ST_START;
                    idx_d   = '0;
                    sr_d    = '0;
                end
            end
            ST_START, ST_LOW: begin
                if (rise) begin
                    state_d = ST_HIGH;
                end else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = ST_RECOVER;
                end
            end
            ST_HIGH: begin
                if (fall) begin
                    if (cnt_q < CNT_W'(MIN_C)) begin
                        err_d   = 1'b1;
                        state_d = ST_RECOVER;
                    end else begin
                        sr_d    = {sr_q[FRAME_BITS-2:0], (cnt_q >= CNT_W'(THR_C))};
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = (idx_q == IDX_W'(FRAME_BITS - 1)) ? ST_CHECK : ST_LOW;
                    end
                end else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = ST_RECOVER;
                end
            end
            ST_CHECK: begin
                if (hdr_ok(sr_q)) begin
                    frame_d = pad_frame_t'(sr_q[PAYLOAD_BITS-1:0]);
                    valid_d = 1'b1;
                end else begin
                    err_d   = 1'b1;
                end
                state_d = ST_TAIL;
            end
            ST_TAIL: begin
                if (rise) begin
                    state_d = ST_IDLE;
                end else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = ST_RECOVER;
                end
            end
            default: begin
                state_d = ST_RECOVER;
            end
        endcase
    end

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_d && (err_cnt_q != {ERR_CNT_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_RECOVER;
            cnt_q     <= '0;
            idx_q     <= '0;
            sr_q      <= '0;
            frame_q   <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            sr_q      <= sr_d;
            frame_q   <= frame_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign buttons     = frame_q.buttons;
    assign joy_x       = frame_q.joy_x;
    assign joy_y       = frame_q.joy_y;
    assign frame_valid = valid_q;
    assign frame_err   = err_q;
    assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_n64_frame_receiver.sv
// Directed bench for n64_frame_receiver: table of whole frames plus hand-built fault sequences.
`timescale 1ns/1ps
module tb_n64_frame_receiver;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        n64_in;
    logic [15:0] buttons;
    logic [7:0]  joy_x;
    logic [7:0]  joy_y;
    logic        frame_valid;
    logic        frame_err;
    logic [7:0]  err_cnt;

    int total = 0;
    int bad   = 0;
    int n_valid = 0;
    int n_err   = 0;

    typedef struct {
        logic [8:0]  hdr;
        logic [31:0] pl;
        int          exp_v;
        int          exp_e;
        logic [15:0] btn;
        logic [7:0]  x;
        logic [7:0]  y;
        logic [7:0]  ec;
    } vec_t;

    vec_t vecs[7];

    always #10 clk = ~clk;

    n64_frame_receiver dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .n64_in      (n64_in),
        .buttons     (buttons),
        .joy_x       (joy_x),
        .joy_y       (joy_y),
        .frame_valid (frame_valid),
        .frame_err   (frame_err),
        .err_cnt     (err_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (frame_valid) n_valid++;
        if (frame_err)   n_err++;
        if (frame_valid || frame_err)
            check("pulse_exclusive", 32'(frame_valid & frame_err), 32'd0);
    end

    task automatic send_bit(input logic b);
        n64_in = 1'b1;
        #(b ? 2500 : 800);
        n64_in = 1'b0;
        #(b ? 1500 : 3200);
    endtask

    task automatic start_frame();
        n64_in = 1'b0;
        #1000;
    endtask

    task automatic send_bits(input logic [40:0] bits, input int first, input int last);
        for (int i = first; i <= last; i++) send_bit(bits[40-i]);
    endtask

    task automatic send_frame(input logic [8:0] h, input logic [31:0] p);
        start_frame();
        send_bits({h, p}, 0, 40);
        n64_in = 1'b1;
    endtask

    task automatic check_outputs(input string tag, input logic [15:0] b, input logic [7:0] x,
                                 input logic [7:0] y, input logic [7:0] ec);
        check({tag, "_btn"}, 32'(buttons), 32'(b));
        check({tag, "_x"},   32'(joy_x),   32'(x));
        check({tag, "_y"},   32'(joy_y),   32'(y));
        check({tag, "_ec"},  32'(err_cnt), 32'(ec));
    endtask

    task automatic apply_vec(input int k);
        int v0;
        int e0;
        string tag;
        v0  = n_valid;
        e0  = n_err;
        tag = $sformatf("v%0d", k);
        send_frame(vecs[k].hdr, vecs[k].pl);
        #12000;
        check({tag, "_valid"}, 32'(n_valid - v0), 32'(vecs[k].exp_v));
        check({tag, "_err"},   32'(n_err - e0),   32'(vecs[k].exp_e));
        check_outputs(tag, vecs[k].btn, vecs[k].x, vecs[k].y, vecs[k].ec);
    endtask

    initial begin
        int v0;
        int e0;
        logic [40:0] good;

        vecs[0] = '{9'h003, 32'h9000_7F81, 1, 0, 16'h9000, 8'h7F, 8'h81, 8'd0};
        vecs[1] = '{9'h003, 32'hFFFF_FFFF, 1, 0, 16'hFFFF, 8'hFF, 8'hFF, 8'd0};
        vecs[2] = '{9'h003, 32'h0000_0000, 1, 0, 16'h0000, 8'h00, 8'h00, 8'd0};
        vecs[3] = '{9'h002, 32'h1234_5678, 0, 1, 16'h0000, 8'h00, 8'h00, 8'd1};
        vecs[4] = '{9'h003, 32'hA5C3_1E80, 1, 0, 16'hA5C3, 8'h1E, 8'h80, 8'd2};
        vecs[5] = '{9'h103, 32'hDEAD_BEEF, 0, 1, 16'hA5C3, 8'h1E, 8'h80, 8'd4};
        vecs[6] = '{9'h003, 32'h0830_4C2D, 1, 0, 16'h0830, 8'h4C, 8'h2D, 8'd0};
        good = {9'h003, 32'h5555_AAAA};

        reset_n = 1'b0;
        n64_in  = 1'b1;
        #100;
        check("rst_valid", 32'(frame_valid), 32'd0);
        check("rst_err",   32'(frame_err),   32'd0);
        check_outputs("rst", 16'h0000, 8'h00, 8'h00, 8'd0);
        reset_n = 1'b1;
        #10000;

        for (int k = 0; k <= 3; k++) apply_vec(k);

        // Line held low for 20us after the high phase of bit 12.
        v0 = n_valid;
        e0 = n_err;
        start_frame();
        send_bits(good, 0, 11);
        n64_in = 1'b1;
        #800;
        n64_in = 1'b0;
        #20000;
        n64_in = 1'b1;
        #12000;
        check("stuck_valid", 32'(n_valid - v0), 32'd0);
        check("stuck_err",   32'(n_err - e0),   32'd1);
        check_outputs("stuck", 16'h0000, 8'h00, 8'h00, 8'd2);

        apply_vec(4);

        // 100ns high glitch inside the low phase of bit 5.
        v0 = n_valid;
        e0 = n_err;
        start_frame();
        send_bits(good, 0, 4);
        n64_in = 1'b1;
        #2500;
        n64_in = 1'b0;
        #1000;
        n64_in = 1'b1;
        #100;
        n64_in = 1'b0;
        #2000;
        send_bits(good, 6, 12);
        n64_in = 1'b1;
        #12000;
        check("glitch_valid", 32'(n_valid - v0), 32'd0);
        check("glitch_err",   32'(n_err - e0),   32'd1);
        check_outputs("glitch", 16'hA5C3, 8'h1E, 8'h80, 8'd3);

        apply_vec(5);

        // Reset asserted in the middle of the payload.
        start_frame();
        send_bits(good, 0, 19);
        n64_in = 1'b1;
        #2500;
        n64_in = 1'b0;
        #1000;
        reset_n = 1'b0;
        #1;
        check_outputs("midrst", 16'h0000, 8'h00, 8'h00, 8'd0);
        #99;
        reset_n = 1'b1;
        v0 = n_valid;
        e0 = n_err;
        #2000;
        send_bits(good, 21, 40);
        n64_in = 1'b1;
        #12000;
        check("midrst_valid", 32'(n_valid - v0), 32'd0);
        check("midrst_err",   32'(n_err - e0),   32'd0);

        apply_vec(6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
